// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the reg_file read-port arbiter.
package rf_arb_pkg;

  // FLUSH is the state the arbiter is in during any cycle in which flush is high.
  typedef enum logic [1:0] {
    ARB    = 2'd0,
    LOCKED = 2'd1,
    FLUSH  = 2'd2
  } arb_state_e;

  // Number of implemented registers in reg_file; higher indices are range errors.
  localparam int RF_NUM_REGS = 10;

  // Widest requester vector the scalar helper below handles.
  localparam int RF_MAX_REQ = 8;

  // Scalar form of the grant rule, for models and checkers that work on a full
  // RF_MAX_REQ-wide vector. Grants the first valid requester at or after ptr,
  // wrapping at num_req. Returns a one-hot vector, or zero when nothing is valid.
  function automatic logic [RF_MAX_REQ-1:0] rr_pick(input logic [RF_MAX_REQ-1:0] valid,
                                                     input logic [2:0]            ptr,
                                                     input int                    num_req);
    logic [RF_MAX_REQ-1:0] grant;
    logic                  found;
    logic [3:0]            idx;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < RF_MAX_REQ; k++) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= 4'(num_req)) idx = idx - 4'(num_req);
      if ((k < num_req) && !found && valid[idx[2:0]]) begin
        grant[idx[2:0]] = 1'b1;
        found           = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/reg_file_rd_arbiter_if.sv
// Requester-side bus of the reg_file read arbiter: requests, acceptance,
// stalls, flush and returned read data.
interface reg_file_rd_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32
) ();

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        stall;
  logic                      flush;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;

  // Pipeline side: issues reads, receives acceptance and data.
  modport master (
    output req_valid, req_addr, req_lock, flush,
    input  req_ready, stall, rsp_valid, rsp_data, rsp_err
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_addr, req_lock, flush,
    output req_ready, stall, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/rf_arb_rr_pick.sv
// Combinational round-robin picker: rotate the request vector so ptr sits at
// bit 0, keep the lowest set bit, rotate the result back.
module rf_arb_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o
);

  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] pick;

  // (p + k) mod NUM_REQ for p < NUM_REQ and k < NUM_REQ; one extra bit holds the carry.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int k);
    logic [PTR_W:0] sum;
    sum = {1'b0, p} + (PTR_W+1)'(k);
    if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
    return sum[PTR_W-1:0];
  endfunction

  // Rotate right by ptr so the highest-priority requester lands at bit 0.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    rot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rot[k] = valid_i[wrap_add(ptr_i, k)];
    end
  end

  // Isolate the lowest set bit of the rotated vector.
  assign pick = rot & (~rot + NUM_REQ'(1));

  // Rotate the one-hot pick back into requester numbering.
  always_comb begin
    grant_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      grant_o[wrap_add(ptr_i, k)] = pick[k];
    end
  end

endmodule

// File: rtl/reg_file_rd_arbiter.sv
// Shares the single registered read port of reg_file among NUM_REQ pipeline
// requesters: round-robin grant, optional lock for atomic read sequences,
// flush, per-requester stall, and a two-stage pipe that returns each read
// two cycles after acceptance. rst_n is expected to be released synchronously
// to clk by the reset distribution upstream.
module reg_file_rd_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = RF_NUM_REGS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reg_file_rd_arbiter_if.slave bus,
  output logic [ADDR_W-1:0]    rf_addr,
  input  logic [DATA_W-1:0]    rf_rdata
);

  localparam int              PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  // One slot of the response pipe: who asked, and whether the index was out of range.
  typedef struct packed {
    logic             vld;
    logic             err;
    logic [PTR_W-1:0] idx;
  } stage_t;

  arb_state_e         state_q, state_d, state_cur;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [ADDR_W-1:0]  rf_addr_q, rf_addr_d;
  stage_t             s1_q, s1_d, s2_q, s2_d;

  logic [NUM_REQ-1:0] owner_mask;
  logic [NUM_REQ-1:0] pick_valid;
  logic [PTR_W-1:0]   pick_ptr;
  logic [NUM_REQ-1:0] grant;
  logic               accept;
  logic [PTR_W-1:0]   acc_idx;
  logic [ADDR_W-1:0]  acc_addr;
  logic               acc_lock;
  logic               acc_err;
  logic               rsp_live;

  // Wrap uses an explicit compare so non-power-of-two NUM_REQ works.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
  endfunction

  // flush overrides whatever the registered state is for the cycle it is high.
  assign state_cur = bus.flush ? FLUSH : state_q;

  // Decode the lock owner into a mask of requesters allowed while LOCKED.
  always_comb begin
    owner_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      owner_mask[i] = (owner_q == PTR_W'(i));
    end
  end

  // One picker serves both modes: all requesters from rr_ptr, or only the owner.
  assign pick_valid = (state_q == LOCKED) ? (bus.req_valid & owner_mask) : bus.req_valid;
  assign pick_ptr   = (state_q == LOCKED) ? owner_q : rr_ptr_q;

  rf_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .valid_i (pick_valid),
    .ptr_i   (pick_ptr),
    .grant_o (grant)
  );

  assign bus.req_ready = (state_cur == FLUSH) ? '0 : grant;
  assign bus.stall     = bus.req_valid & ~bus.req_ready;
  assign accept        = |bus.req_ready;

  // Pull index, address and lock of the accepted requester out of the one-hot ready.
  always_comb begin
    acc_idx  = '0;
    acc_addr = '0;
    acc_lock = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req_ready[i]) begin
        acc_idx  = acc_idx | PTR_W'(i);
        acc_addr = acc_addr | bus.req_addr[i*ADDR_W +: ADDR_W];
        acc_lock = acc_lock | bus.req_lock[i];
      end
    end
    acc_err = (32'(acc_addr) >= 32'(NUM_REGS));
  end

  // Next-state logic for the FSM, pointers, reg_file address and response pipe.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    rf_addr_d = rf_addr_q;
    s1_d      = '0;
    s2_d      = s1_q;

    if (bus.flush) begin
      // Drop everything in flight and release any lock; rr_ptr is kept.
      state_d = ARB;
      s2_d    = '0;
    end else begin
      s1_d = '{vld: accept, err: acc_err, idx: acc_idx};
      // An out-of-range read still takes its slot but leaves rf_addr alone.
      if (accept && !acc_err) rf_addr_d = acc_addr;

      case (state_q)
        ARB: begin
          if (accept) begin
            rr_ptr_d = ptr_inc(acc_idx);
            if (acc_lock) begin
              state_d = LOCKED;
              owner_d = acc_idx;
            end
          end
        end
        LOCKED: begin
          // Only the owner can be accepted here; dropping lock hands back to round-robin.
          if (accept && !acc_lock) begin
            state_d  = ARB;
            rr_ptr_d = ptr_inc(owner_q);
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      rf_addr_q <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      rf_addr_q <= rf_addr_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
    end
  end

  assign rf_addr = rf_addr_q;

  // A returning read is suppressed in a flush cycle along with everything else in flight.
  assign rsp_live = s2_q.vld & ~bus.flush;

  // Route the read in stage 2 back to its requester; range errors return zero data.
  always_comb begin
    bus.rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.rsp_valid[i] = rsp_live && (s2_q.idx == PTR_W'(i));
    end
    bus.rsp_err  = rsp_live & s2_q.err;
    bus.rsp_data = (rsp_live && !s2_q.err) ? rf_rdata : '0;
  end

endmodule

// File: tb/tb_reg_file_rd_arbiter.sv
// Self-checking bench for reg_file_rd_arbiter: a directed vector table, hand
// sequences for flush, lock and reset corners, and random traffic compared
// against a transaction-level model of the arbitration rules.
module tb_reg_file_rd_arbiter;

  localparam int NR    = 4;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int NREGS = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_rdata;

  always #5 clk = ~clk;

  reg_file_rd_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  reg_file_rd_arbiter #(
    .NUM_REQ (NR),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .NUM_REGS(NREGS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .rf_addr (rf_addr),
    .rf_rdata(rf_rdata)
  );

  // Register contents: a distinct value per index.
  function automatic logic [31:0] rv(input logic [3:0] a);
    return 32'hA5C3_0000 ^ ({28'd0, a} * 32'h0101_1357);
  endfunction

  // reg_file stand-in with its one-cycle registered read.
  always_ff @(posedge clk) rf_rdata <= rv(rf_addr);

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         due;
    int         idx;
    logic [3:0] addr;
  } pend_t;

  pend_t      q[$];
  int         m_ptr;
  int         m_owner;
  logic [3:0] m_rf_addr;

  logic [3:0]  e_ready, e_stall, e_rv, e_rfa;
  logic        e_err;
  logic [31:0] e_data;
  logic [3:0]  g_ready, g_stall, g_rv, g_rfa;
  logic        g_err;
  logic [31:0] g_data;

  task automatic model_reset();
    m_ptr     = 0;
    m_owner   = -1;
    m_rf_addr = '0;
    q.delete();
  endtask

  task automatic model_expect(input logic [3:0] v, input logic f);
    e_ready = '0;
    if (!f) begin
      if (m_owner >= 0) begin
        if (v[m_owner]) e_ready[m_owner] = 1'b1;
      end else begin
        for (int k = 0; k < NR; k++) begin
          int j;
          j = (m_ptr + k) % NR;
          if (v[j]) begin
            e_ready[j] = 1'b1;
            break;
          end
        end
      end
    end
    e_stall = v & ~e_ready;
    e_rv    = '0;
    e_err   = 1'b0;
    e_data  = '0;
    if (!f && q.size() > 0 && q[0].due == cyc) begin
      e_rv[q[0].idx] = 1'b1;
      e_err          = int'(q[0].addr) >= NREGS;
      e_data         = e_err ? 32'd0 : rv(q[0].addr);
    end
    e_rfa = m_rf_addr;
  endtask

  task automatic model_commit(input logic [15:0] a, input logic [3:0] l, input logic f);
    if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
    if (f) begin
      q.delete();
      m_owner = -1;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (e_ready[i]) begin
          pend_t p;
          p.due  = cyc + 2;
          p.idx  = i;
          p.addr = a[i*4 +: 4];
          q.push_back(p);
          if (int'(p.addr) < NREGS) m_rf_addr = p.addr;
          if (m_owner < 0) begin
            m_ptr = (i + 1) % NR;
            if (l[i]) m_owner = i;
          end else if (!l[i]) begin
            m_owner = -1;
            m_ptr   = (i + 1) % NR;
          end
        end
      end
    end
    cyc++;
  endtask

  // One clock: drive after the falling edge, sample and compare before the rising edge.
  task automatic step(input logic [3:0] v, input logic [15:0] a, input logic [3:0] l, input logic f);
    @(negedge clk);
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.req_lock  = l;
    bus.flush     = f;
    #2;
    model_expect(v, f);
    g_ready = bus.req_ready;
    g_stall = bus.stall;
    g_rv    = bus.rsp_valid;
    g_err   = bus.rsp_err;
    g_data  = bus.rsp_data;
    g_rfa   = rf_addr;
    check("ready",     64'(g_ready), 64'(e_ready));
    check("stall",     64'(g_stall), 64'(e_stall));
    check("rsp_valid", 64'(g_rv),    64'(e_rv));
    check("rsp_err",   64'(g_err),   64'(e_err));
    if (e_rv != 4'd0) check("rsp_data", 64'(g_data), 64'(e_data));
    check("rf_addr",   64'(g_rfa),   64'(e_rfa));
    @(posedge clk);
    model_commit(a, l, f);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [3:0]  v;
    logic [15:0] a;
    logic [3:0]  l;
    logic        f;
    logic [3:0]  e_ready;
    logic [3:0]  e_rv;
    logic        e_err;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[18];

  function automatic logic [15:0] pack(input int a0, input int a1, input int a2, input int a3);
    return {4'(a3), 4'(a2), 4'(a1), 4'(a0)};
  endfunction

  function automatic vec_t mk(input logic [3:0] v, input logic [15:0] a, input logic [3:0] l,
                              input logic [3:0] er);
    vec_t r;
    r.v = v; r.a = a; r.l = l; r.f = 1'b0; r.e_ready = er;
    r.e_rv = '0; r.e_err = 1'b0; r.e_data = '0;
    return r;
  endfunction

  initial begin
    logic [3:0]  rv_v;
    logic [15:0] rv_a;
    logic [3:0]  rv_l;
    logic        rv_f;

    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_lock  = '0;
    bus.flush     = 1'b0;
    model_reset();

    // Rows 0-7: all four requesting, grants rotate 0,1,2,3,0,1,2,3.
    for (int k = 0; k < 8; k++) begin
      tbl[k] = mk(4'hF, pack(k % 10, (k + 1) % 10, (k + 2) % 10, (k + 3) % 10), 4'h0,
                  4'(1 << (k % 4)));
    end
    tbl[8] = mk(4'h0, 16'h0, 4'h0, 4'h0);
    tbl[9] = mk(4'h0, 16'h0, 4'h0, 4'h0);
    // Each of those grants returns two rows later with the granted requester's register.
    for (int k = 2; k < 10; k++) begin
      tbl[k].e_rv   = 4'(1 << ((k - 2) % 4));
      tbl[k].e_data = rv(4'(((k - 2) + (k - 2) % 4) % 10));
    end
    // Lock: req0 alone moves rr_ptr to 1, then req1 holds the port for two reads.
    tbl[10] = mk(4'b0001, pack(5, 0, 0, 0), 4'b0000, 4'b0001);
    tbl[11] = mk(4'b0111, pack(5, 2, 7, 0), 4'b0010, 4'b0010);
    tbl[12] = mk(4'b0111, pack(5, 3, 7, 0), 4'b0000, 4'b0010);
    tbl[13] = mk(4'b0111, pack(5, 3, 7, 0), 4'b0000, 4'b0100);
    tbl[14] = mk(4'b0000, 16'h0,            4'b0000, 4'b0000);
    // Range error: index 12 returns on schedule with err and zero data.
    tbl[15] = mk(4'b0100, pack(0, 0, 12, 0), 4'b0000, 4'b0100);
    tbl[16] = mk(4'b0000, 16'h0,            4'b0000, 4'b0000);
    tbl[17] = mk(4'b0000, 16'h0,            4'b0000, 4'b0000);
    tbl[12].e_rv = 4'b0001; tbl[12].e_data = rv(4'd5);
    tbl[13].e_rv = 4'b0010; tbl[13].e_data = rv(4'd2);
    tbl[14].e_rv = 4'b0010; tbl[14].e_data = rv(4'd3);
    tbl[15].e_rv = 4'b0100; tbl[15].e_data = rv(4'd7);
    tbl[17].e_rv = 4'b0100; tbl[17].e_err  = 1'b1; tbl[17].e_data = 32'd0;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready",     64'(bus.req_ready), 64'(0));
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("rst_rsp_err",   64'(bus.rsp_err),   64'(0));
    check("rst_rsp_data",  64'(bus.rsp_data),  64'(0));
    check("rst_rf_addr",   64'(rf_addr),       64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 18; r++) begin
      step(tbl[r].v, tbl[r].a, tbl[r].l, tbl[r].f);
      check("tbl_ready", 64'(g_ready), 64'(tbl[r].e_ready));
      check("tbl_stall", 64'(g_stall), 64'(tbl[r].v & ~tbl[r].e_ready));
      check("tbl_rsp_valid", 64'(g_rv), 64'(tbl[r].e_rv));
      check("tbl_rsp_err", 64'(g_err), 64'(tbl[r].e_err));
      if (tbl[r].e_rv != 4'd0) check("tbl_rsp_data", 64'(g_data), 64'(tbl[r].e_data));
    end

    // Accept at T, flush at T+1: nothing returns, no ready during flush, accepts resume at T+2.
    step(4'b0001, pack(4, 0, 0, 0), 4'b0000, 1'b0);
    check("fl_accept_T", 64'(g_ready), 64'(4'b0001));
    step(4'b0010, pack(0, 6, 0, 0), 4'b0000, 1'b1);
    check("fl_no_ready_T1", 64'(g_ready), 64'(0));
    step(4'b0010, pack(0, 6, 0, 0), 4'b0000, 1'b0);
    check("fl_ready_T2", 64'(g_ready), 64'(4'b0010));
    check("fl_no_rsp_T2", 64'(g_rv), 64'(0));
    step(4'b0000, 16'h0, 4'b0000, 1'b0);
    check("fl_no_rsp_T3", 64'(g_rv), 64'(0));
    step(4'b0000, 16'h0, 4'b0000, 1'b0);
    check("fl_rsp_T4", 64'(g_rv), 64'(4'b0010));

    // Flush releases a lock.
    step(4'b0001, pack(1, 0, 0, 0), 4'b0001, 1'b0);
    step(4'b0011, pack(1, 8, 0, 0), 4'b0001, 1'b1);
    step(4'b0010, pack(0, 8, 0, 0), 4'b0000, 1'b0);
    check("fl_unlock", 64'(g_ready), 64'(4'b0010));
    step(4'b0000, 16'h0, 4'b0000, 1'b0);
    step(4'b0000, 16'h0, 4'b0000, 1'b0);

    // Reset with both pipe stages full: rsp_valid drops at once, rr_ptr back to 0.
    step(4'hF, pack(1, 2, 3, 4), 4'h0, 1'b0);
    step(4'hF, pack(1, 2, 3, 4), 4'h0, 1'b0);
    @(negedge clk);
    bus.req_valid = '0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("mid_rst_rf_addr",   64'(rf_addr),       64'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1000, pack(0, 0, 0, 9), 4'h0, 1'b0);
    check("wrap_grant3", 64'(g_ready), 64'(4'b1000));
    step(4'b1111, pack(1, 1, 1, 1), 4'h0, 1'b0);
    check("wrap_ptr0", 64'(g_ready), 64'(4'b0001));

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rv_v = 4'($urandom);
      rv_a = 16'($urandom);
      rv_l = 4'($urandom) & 4'($urandom);
      rv_f = ($urandom_range(0, 19) == 0);
      step(rv_v, rv_a, rv_l, rv_f);
    end
    repeat (3) step(4'h0, 16'h0, 4'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
